// File: rtl/uart_tx_buffered_pkg.sv
// rtl/uart_tx_buffered_pkg.sv - shared types and constants for the buffered UART transmitter
package uart_tx_buffered_pkg;

    // Serializer state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // One start bit, eight data bits, one stop bit
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    // Smallest bit period the serializer can produce
    localparam logic [31:0] MIN_DIV = 32'd2;

    // Clamp the programmed divider so 0 and 1 behave as the minimum period
    function automatic logic [31:0] effective_div(input logic [31:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - byte write handshake between a source and the transmitter
interface uart_tx_buffered_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy output and show-ahead read data
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage array; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - 8N1 UART transmitter fed from a byte FIFO with programmable bit period
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] DEFAULT_DIV = 32'd140
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cfg_div_we,
    input  logic [31:0]            cfg_div_di,
    output logic [31:0]            cfg_div_do,
    uart_tx_buffered_if.slave      wr,
    output logic                   ser_tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
);

    tx_state_t   state;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_cnt;
    logic [31:0] div_cnt;
    logic [31:0] div_latched;
    logic [31:0] div_reg;
    logic        line_active;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        push;
    logic [7:0]  fifo_head;
    logic        div_end;

    assign cfg_div_do  = div_reg;
    assign wr.wr_ready = !fifo_full;
    assign push        = wr.wr_valid && wr.wr_ready;

    // Last cycle of the current bit period
    assign div_end = (div_cnt == div_latched - 32'd1);

    // Pop from IDLE, or at the end of STOP so frames run back to back
    assign fifo_rd = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && div_end));

    // ser_tx lags the state by one cycle, so busy also covers that trailing stop-bit cycle
    assign busy = (state != ST_IDLE) || line_active || !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (push),
        .wr_data (wr.wr_data),
        .full    (fifo_full),
        .rd_en   (fifo_rd),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Divider register; new values are only picked up when a frame starts
    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_reg <= DEFAULT_DIV;
        end else if (cfg_div_we) begin
            div_reg <= cfg_div_di;
        end
    end

    // Serializer FSM with registered line output
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            div_latched <= MIN_DIV;
            ser_tx      <= 1'b1;
            line_active <= 1'b0;
        end else begin
            line_active <= (state != ST_IDLE);

            case (state)
                ST_START: ser_tx <= 1'b0;
                ST_DATA:  ser_tx <= shift_reg[0];
                default:  ser_tx <= 1'b1;
            endcase

            case (state)
                ST_IDLE: begin
                    if (fifo_rd) begin
                        shift_reg   <= fifo_head;
                        div_latched <= effective_div(div_reg);
                        div_cnt     <= '0;
                        bit_cnt     <= '0;
                        state       <= ST_START;
                    end
                end

                ST_START: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end else begin
                        div_cnt <= div_cnt + 32'd1;
                    end
                end

                ST_DATA: begin
                    if (div_end) begin
                        div_cnt   <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 32'd1;
                    end
                end

                ST_STOP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (fifo_rd) begin
                            shift_reg   <= fifo_head;
                            div_latched <= effective_div(div_reg);
                            bit_cnt     <= '0;
                            state       <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt + 32'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

    localparam int DEPTH   = 8;
    localparam int LOG_LEN = 65536;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_div_we = 1'b0;
    logic [31:0] cfg_div_di = '0;
    logic [31:0] cfg_div_do;
    logic        ser_tx;
    logic        busy;
    logic [3:0]  fifo_level;

    uart_tx_buffered_if wr_if ();

    uart_tx_buffered #(
        .DEPTH       (DEPTH),
        .DEFAULT_DIV (32'd140)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_div_we (cfg_div_we),
        .cfg_div_di (cfg_div_di),
        .cfg_div_do (cfg_div_do),
        .wr         (wr_if),
        .ser_tx     (ser_tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic tx_log [LOG_LEN];
    always @(negedge clk) if (cyc < LOG_LEN) tx_log[cyc] = ser_tx;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic set_div(input logic [31:0] v);
        cfg_div_we = 1'b1;
        cfg_div_di = v;
        @(negedge clk);
        cfg_div_we = 1'b0;
        chk("cfg_div_do", cfg_div_do, v);
    endtask

    task automatic push(input logic [7:0] b, output int acc);
        int waited;
        waited = 0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = b;
        while (!wr_if.wr_ready && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (!wr_if.wr_ready) chk("push_timeout_ready", 32'(wr_if.wr_ready), 32'd1);
        acc = cyc + 1;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
    endtask

    // Expected line: start bit low, data LSB first, stop bit high, each held d cycles
    task automatic check_frame(input string tag, input int s, input int d, input logic [7:0] b);
        logic [9:0] bits;
        logic [7:0] dec;
        int bad;
        bits = {1'b1, b, 1'b0};
        bad = 0;
        for (int i = 0; i < 10 * d; i++) if (tx_log[s + i] !== bits[i / d]) bad++;
        chk($sformatf("%s_wave", tag), 32'(bad), 32'd0);
        for (int j = 0; j < 8; j++) dec[j] = tx_log[s + (j + 1) * d + d / 2];
        chk($sformatf("%s_byte", tag), 32'(dec), 32'(b));
    endtask

    task automatic check_idle(input string tag, input int from, input int to);
        int bad;
        bad = 0;
        for (int i = from; i <= to; i++) if (tx_log[i] !== 1'b1) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int acc;
        int acc_last;
        int s;
        int r;
        int t;
        logic [7:0] rb [10];
        logic [7:0] msg [3];

        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_cfg_div", cfg_div_do, 32'd140);
        resetn = 1'b1;
        @(negedge clk);

        // Single 'A' at the default divider, first byte after reset
        push(8'h41, acc);
        s = acc + 2;
        wait_until(s + 1400 + 10);
        chk("s1_line_high_before_start", 32'(tx_log[s - 1]), 32'd1);
        check_frame("s1_A", s, 140, 8'h41);
        chk("s1_busy_after", 32'(busy), 32'd0);

        // Three bytes back to back, no idle gap, busy falls after the last stop bit
        msg[0] = 8'h48;
        msg[1] = 8'h69;
        msg[2] = 8'h0A;
        push(msg[0], acc);
        s = acc + 2;
        push(msg[1], acc_last);
        push(msg[2], acc_last);
        wait_until(s + 4200 - 1);
        chk("s2_busy_last_stop", 32'(busy), 32'd1);
        @(negedge clk);
        chk("s2_busy_fall", 32'(busy), 32'd0);
        wait_until(s + 4200 + 10);
        for (int i = 0; i < 3; i++) check_frame($sformatf("s2_f%0d", i), s + i * 1400, 140, msg[i]);
        check_idle("s2_idle_after", s + 4200, s + 4208);

        // Fill the FIFO during the first frame; the 10th byte waits for a pop
        set_div(32'd20);
        for (int i = 0; i < 10; i++) rb[i] = 8'($urandom);
        push(rb[0], acc);
        s = acc + 2;
        for (int i = 1; i < 9; i++) push(rb[i], acc_last);
        chk("s3_level_full", 32'(fifo_level), 32'd8);
        chk("s3_ready_low_full", 32'(wr_if.wr_ready), 32'd0);
        push(rb[9], acc_last);
        chk("s3_held_byte_accept_edge", 32'(acc_last), 32'(s + 200));
        wait_until(s + 2000 + 10);
        for (int i = 0; i < 10; i++) check_frame($sformatf("s3_f%0d", i), s + i * 200, 20, rb[i]);

        // Divider write mid-frame only affects the next frame
        set_div(32'd140);
        rb[0] = 8'($urandom);
        rb[1] = 8'($urandom);
        push(rb[0], acc);
        s = acc + 2;
        push(rb[1], acc_last);
        wait_until(s + 700);
        set_div(32'd70);
        wait_until(s + 1400 + 700 + 10);
        check_frame("s4_f0_div140", s, 140, rb[0]);
        check_frame("s4_f1_div70", s + 1400, 70, rb[1]);

        // Reset during data bit 3 with four bytes queued
        set_div(32'd140);
        for (int i = 0; i < 5; i++) rb[i] = 8'($urandom);
        push(rb[0], acc);
        s = acc + 2;
        for (int i = 1; i < 5; i++) push(rb[i], acc_last);
        set_div(32'd70);
        chk("s5_level_queued", 32'(fifo_level), 32'd4);
        wait_until(s + 4 * 140 + 70);
        resetn = 1'b0;
        r = cyc;
        @(negedge clk);
        chk("s5_rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("s5_rst_level", 32'(fifo_level), 32'd0);
        chk("s5_rst_cfg_div", cfg_div_do, 32'd140);
        chk("s5_rst_ready", 32'(wr_if.wr_ready), 32'd1);
        chk("s5_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        t = cyc;
        wait_until(t + 1600);
        check_idle("s5_no_residual", r + 1, cyc - 1);
        chk("s5_busy_after", 32'(busy), 32'd0);

        // Divider 0 and 1 clamp to two cycles per bit; first byte after reset keeps k+2 latency
        set_div(32'd0);
        rb[0] = 8'($urandom);
        push(rb[0], acc);
        s = acc + 2;
        wait_until(s + 20 + 5);
        chk("s6_line_high_before_start", 32'(tx_log[s - 1]), 32'd1);
        check_frame("s6_div0", s, 2, rb[0]);
        set_div(32'd1);
        rb[1] = 8'($urandom);
        push(rb[1], acc);
        s = acc + 2;
        wait_until(s + 20 + 5);
        check_frame("s6_div1", s, 2, rb[1]);
        chk("s6_busy_after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter DEPTH, default 8: transmit FIFO depth in bytes; SHALL be a power of two, 2..64.
REQ-002 Parameter DEFAULT_DIV, default 140: clk cycles per serial bit, loaded into the divider register at reset.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 cfg_div_we  input  1  when high, SHALL load cfg_div_di into the divider register.
REQ-006 cfg_div_di  input  32  new clk-cycles-per-bit value.
REQ-007 cfg_div_do  output  32  current divider register value.
REQ-008 wr_valid  input  1  byte offered for transmission.
REQ-009 wr_data  input  8  byte to transmit.
REQ-010 wr_ready  output  1  FIFO can accept; SHALL be high exactly when FIFO level < DEPTH.
REQ-011 ser_tx  output  1  serial line (8N1, idle high), registered.
REQ-012 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-013 fifo_level  output  $clog2(DEPTH)+1  bytes currently queued.

Function
REQ-014 A byte SHALL be accepted on any edge where wr_valid && wr_ready; an offer while wr_ready is low SHALL be ignored, and the source holds it.
REQ-015 The serializer FSM SHALL use the states IDLE, START, DATA and STOP.
REQ-016 IDLE: when the FIFO is non-empty, the FSM SHALL pop the head into the shift register, latch the effective divider, and enter START.
REQ-017 ser_tx SHALL be 0 in START, shift_reg[0] in DATA (LSB first), and 1 in STOP and IDLE.
REQ-018 Each of START, the 8 DATA bits and STOP SHALL hold ser_tx for exactly the latched divider number of cycles; a frame therefore lasts 10*div cycles.
REQ-019 The effective divider SHALL be max(cfg_div_do, 2); values 0 and 1 SHALL behave as 2.
REQ-020 A divider write SHALL take effect from the next frame only; the current frame SHALL keep its latched value.
REQ-021 Latency: for a byte accepted at edge k into an empty FIFO with the FSM in IDLE, ser_tx SHALL fall at edge k+2.
REQ-022 At the end of STOP, a non-empty FIFO SHALL cause an immediate pop and a direct STOP->START transition, with no idle cycle between frames.
REQ-023 At the end of STOP, an empty FIFO SHALL cause a return to IDLE.
REQ-024 A simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-025 When full, a pop SHALL raise wr_ready on the following cycle. There is no same-cycle pass-through.
REQ-026 FIFO read and write pointers SHALL wrap modulo DEPTH; fifo_level SHALL never exceed DEPTH or go below 0.
REQ-027 busy SHALL fall in the first cycle the FSM is in IDLE with fifo_level == 0.

Reset
REQ-028 While resetn is low, the following SHALL hold on every edge: ser_tx=1, FSM=IDLE, FIFO empty, fifo_level=0, wr_ready=1, busy=0, cfg_div_do=DEFAULT_DIV, bit counter and divider counter = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame, drive ser_tx high on the next edge, and discard all queued bytes.
REQ-030 The first byte accepted after resetn rises SHALL follow REQ-021 timing.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the frame-length constant (10 bits) and the minimum divider constant (2).
REQ-032 The FIFO SHALL be a separate sub-module, sync_fifo, parameterized by width and depth, with a level output.
REQ-033 The implementation SHALL be 120-400 lines of RTL; no asynchronous logic and no multiple clocks.

Verification
REQ-034 Scenario: div=140, write 0x41 -> ser_tx falls 2 cycles after accept, then 10 bits of 140 cycles each, bits 1,0,0,0,0,0,1,0 LSB first, stop bit high; the monitor decodes 'A'.
REQ-035 Scenario: write 0x48, 0x69, 0x0A back-to-back -> 30 contiguous bit periods with no idle gap; the decoded bytes are 'H', 'i', 10; busy falls the cycle after the final stop bit.
REQ-036 Scenario: DEPTH=8, push 10 bytes continuously during the first frame -> wr_ready low once level=8, the 10th byte is held until a pop, and all 10 bytes appear in order.
REQ-037 Scenario: write div=70 mid-frame under div=140 -> the current frame stays at 140 cycles/bit and the next frame runs at 70 cycles/bit.
REQ-038 Scenario: assert resetn=0 during DATA bit 3 with 4 bytes queued -> ser_tx=1 on the next edge, fifo_level=0, cfg_div_do=140; after release, no residual byte is transmitted.
REQ-039 Scenario: div=0 and div=1 -> each bit lasts exactly 2 cycles.
